mapa_grid: RTL and testbench

Parametrised successor to the snake-game map store. Holds a MAPA_HEIGHT x MAPA_WIDTH grid of CELL_BITS-wide cells and serves two clients:
- VGA pixel lookup, pipelined, with colour decode.
- Game-logic read/modify/write port with a handshake, used by the snake FSMs for collision checks and updates.
Adds a hardware clear sweep at reset or on request, and out-of-range protection.

---
 rtl/mapa_pkg.sv | 29 ++
 rtl/mapa_color_lut.sv | 48 ++++
 rtl/mapa_grid.sv | 164 ++++++++++++++++
 tb/tb_mapa_grid.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapa_pkg.sv
// rtl/mapa_pkg.sv - cell codes, FSM states and colour levels for the map store
package mapa_pkg;

  localparam logic [3:0] CELL_NADA      = 4'b0000;
  localparam logic [3:0] CELL_OBSTACULO = 4'b0001;
  localparam logic [3:0] CELL_FRUTA     = 4'b0010;
  localparam int         COBRA_BIT      = 3;
  localparam int         COBRA_SEL_BIT  = 2;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_ACCESS
  } state_e;

  // Colour levels are width-independent; the LUT expands them to COLOR_BITS.
  typedef enum logic [1:0] {
    LVL_OFF,
    LVL_ONE,
    LVL_FULL
  } level_e;

  typedef struct packed {
    level_e r;
    level_e g;
    level_e b;
  } rgb_lvl_t;

endpackage

// File: rtl/mapa_color_lut.sv
// rtl/mapa_color_lut.sv - combinational cell-to-RGB decode, shared with the minimap
module mapa_color_lut
  import mapa_pkg::*;
#(
  parameter int CELL_BITS  = 4,
  parameter int COLOR_BITS = 2
) (
  input  logic [CELL_BITS-1:0]  cell_i,
  input  logic                  blank_i,
  output logic [COLOR_BITS-1:0] r_o,
  output logic [COLOR_BITS-1:0] g_o,
  output logic [COLOR_BITS-1:0] b_o
);

  rgb_lvl_t   lvl;
  logic [3:0] lo;
  logic       hi_zero;

  assign lo      = cell_i[3:0];
  assign hi_zero = (cell_i >> 4) == '0;

  function automatic logic [COLOR_BITS-1:0] expand(input level_e l);
    case (l)
      LVL_FULL: return '1;
      LVL_ONE:  return COLOR_BITS'(1);
      default:  return '0;
    endcase
  endfunction

  always_comb begin
    lvl = '{r: LVL_OFF, g: LVL_OFF, b: LVL_OFF};
    if (!blank_i && hi_zero) begin
      if (lo == CELL_FRUTA) begin
        lvl = '{r: LVL_FULL, g: LVL_OFF, b: LVL_OFF};
      end else if (lo == CELL_OBSTACULO) begin
        lvl = '{r: LVL_FULL, g: LVL_ONE, b: LVL_OFF};
      end else if (lo[COBRA_BIT]) begin
        lvl = lo[COBRA_SEL_BIT] ? '{r: LVL_OFF, g: LVL_OFF, b: LVL_FULL}
                                : '{r: LVL_OFF, g: LVL_FULL, b: LVL_OFF};
      end
    end
  end

  assign r_o = expand(lvl.r);
  assign g_o = expand(lvl.g);
  assign b_o = expand(lvl.b);

endmodule

// File: rtl/mapa_grid.sv
// rtl/mapa_grid.sv - snake map store: pipelined VGA lookup, game RMW port, clear sweep
module mapa_grid
  import mapa_pkg::*;
#(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int CELL_BITS   = 4,
  parameter int CELL_SHIFT  = 4,
  parameter int COLOR_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vga_read,
  input  logic [9:0]            vga_x,
  input  logic [9:0]            vga_y,
  output logic [COLOR_BITS-1:0] mapa_R,
  output logic [COLOR_BITS-1:0] mapa_G,
  output logic [COLOR_BITS-1:0] mapa_B,
  output logic                  mapa_valid,
  input  logic                  game_req,
  input  logic                  game_we,
  input  logic [5:0]            game_x,
  input  logic [4:0]            game_y,
  input  logic [CELL_BITS-1:0]  game_wdata,
  output logic                  game_ready,
  output logic                  game_ack,
  output logic [CELL_BITS-1:0]  game_rdata,
  output logic                  game_err,
  input  logic                  clear_start,
  output logic                  busy
);

  localparam int                   DEPTH     = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int                   ADDR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CELL_BITS-1:0] OBST      = CELL_BITS'(CELL_OBSTACULO);

  logic [CELL_BITS-1:0] mem [DEPTH];

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]    acc_addr_q;
  logic                 acc_we_q, acc_err_q;
  logic [CELL_BITS-1:0] acc_wdata_q;
  logic [CELL_BITS-1:0] game_cell_q, s1_cell_q;
  logic                 s1_valid_q, s1_inr_q;

  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [CELL_BITS-1:0] mem_wdata;

  logic                 game_inr, accept;
  logic [ADDR_W-1:0]    game_addr;
  logic [9:0]           vga_cx, vga_cy;
  logic                 vga_inr;
  logic [ADDR_W-1:0]    vga_addr;
  logic [COLOR_BITS-1:0] lut_r, lut_g, lut_b;

  // Out-of-range coordinates are forced to address 0 so no read or write aliases.
  assign game_inr  = (32'(game_x) < MAPA_WIDTH) && (32'(game_y) < MAPA_HEIGHT);
  assign game_addr = game_inr ? ADDR_W'(32'(game_y) * MAPA_WIDTH + 32'(game_x)) : '0;
  assign accept    = (state_q == ST_IDLE) && game_req && !clear_start;

  assign vga_cx   = vga_x >> CELL_SHIFT;
  assign vga_cy   = vga_y >> CELL_SHIFT;
  assign vga_inr  = (32'(vga_cx) < MAPA_WIDTH) && (32'(vga_cy) < MAPA_HEIGHT);
  assign vga_addr = vga_inr ? ADDR_W'(32'(vga_cy) * MAPA_WIDTH + 32'(vga_cx)) : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = acc_addr_q;
    mem_wdata = acc_wdata_q;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (clear_start) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (game_req) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_we  = acc_we_q;
        state_d = clear_start ? ST_CLEAR : ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Non-blocking reads give read-before-write against a same-edge write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    game_cell_q <= mem[game_addr];
    s1_cell_q   <= mem[vga_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      acc_addr_q  <= '0;
      acc_we_q    <= 1'b0;
      acc_err_q   <= 1'b0;
      acc_wdata_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_inr_q    <= 1'b0;
      mapa_valid  <= 1'b0;
      mapa_R      <= '0;
      mapa_G      <= '0;
      mapa_B      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        acc_addr_q  <= game_addr;
        acc_we_q    <= game_we && game_inr;
        acc_err_q   <= !game_inr;
        acc_wdata_q <= game_wdata;
      end
      s1_valid_q <= vga_read;
      s1_inr_q   <= vga_inr;
      mapa_valid <= s1_valid_q;
      if (s1_valid_q) begin
        mapa_R <= lut_r;
        mapa_G <= lut_g;
        mapa_B <= lut_b;
      end
    end
  end

  mapa_color_lut #(
    .CELL_BITS  (CELL_BITS),
    .COLOR_BITS (COLOR_BITS)
  ) u_lut (
    .cell_i  (s1_cell_q),
    .blank_i (!s1_inr_q || (state_q == ST_CLEAR)),
    .r_o     (lut_r),
    .g_o     (lut_g),
    .b_o     (lut_b)
  );

  assign game_ready = (state_q == ST_IDLE);
  assign game_ack   = (state_q == ST_ACCESS);
  assign game_err   = game_ack && acc_err_q;
  assign game_rdata = !game_ack ? '0 : (acc_err_q ? OBST : game_cell_q);
  assign busy       = rst_n && (state_q == ST_CLEAR);

endmodule

// File: tb/tb_mapa_grid.sv
// tb/tb_mapa_grid.sv - scoreboard bench for mapa_grid
module tb_mapa_grid;

  localparam int W = 40;
  localparam int H = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vga_read = 1'b0;
  logic [9:0] vga_x = '0, vga_y = '0;
  logic [1:0] mapa_R, mapa_G, mapa_B;
  logic       mapa_valid;
  logic       game_req = 1'b0, game_we = 1'b0;
  logic [5:0] game_x = '0;
  logic [4:0] game_y = '0;
  logic [3:0] game_wdata = '0;
  logic       game_ready, game_ack, game_err;
  logic [3:0] game_rdata;
  logic       clear_start = 1'b0;
  logic       busy;

  always #5 clk = ~clk;

  mapa_grid dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_read    (vga_read),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .mapa_R      (mapa_R),
    .mapa_G      (mapa_G),
    .mapa_B      (mapa_B),
    .mapa_valid  (mapa_valid),
    .game_req    (game_req),
    .game_we     (game_we),
    .game_x      (game_x),
    .game_y      (game_y),
    .game_wdata  (game_wdata),
    .game_ready  (game_ready),
    .game_ack    (game_ack),
    .game_rdata  (game_rdata),
    .game_err    (game_err),
    .clear_start (clear_start),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  typedef struct packed {
    logic [3:0] rdata;
    logic       err;
  } game_exp_t;

  game_exp_t  game_q[$];
  logic [5:0] vga_q[$];
  logic [3:0] model [H][W];
  logic [5:0] last_rgb = '0;

  function automatic logic [5:0] rgb_of(input logic [3:0] c);
    if (c == 4'b0010) return 6'b11_00_00;
    if (c == 4'b0001) return 6'b11_01_00;
    if (c[3] && !c[2]) return 6'b00_11_00;
    if (c[3] && c[2]) return 6'b00_00_11;
    return 6'b00_00_00;
  endfunction

  task automatic clear_model();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        model[y][x] = 4'b0000;
  endtask

  always @(negedge clk) begin
    if (game_ack) begin
      if (game_q.size() == 0) begin
        check("game_ack_unexpected", 32'd1, 32'd0);
      end else begin
        game_exp_t e;
        e = game_q.pop_front();
        check("game_rdata", 32'(game_rdata), 32'(e.rdata));
        check("game_err", 32'(game_err), 32'(e.err));
      end
    end
    if (mapa_valid) begin
      if (vga_q.size() == 0) begin
        check("vga_valid_unexpected", 32'd1, 32'd0);
      end else begin
        logic [5:0] ev;
        ev = vga_q.pop_front();
        last_rgb = ev;
        check("vga_rgb", 32'({mapa_R, mapa_G, mapa_B}), 32'(ev));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic game_drive(input int x, input int y, input logic we, input logic [3:0] wd);
    game_exp_t e;
    logic inr;
    inr = (x < W) && (y < H);
    game_req = 1'b1;
    game_we = we;
    game_x = 6'(x);
    game_y = 5'(y);
    game_wdata = wd;
    e.err = !inr;
    e.rdata = 4'b0001;
    if (inr) e.rdata = model[y][x];
    game_q.push_back(e);
    if (we && inr) model[y][x] = wd;
  endtask

  task automatic game_access(input int x, input int y, input logic we, input logic [3:0] wd);
    check("game_ready", 32'(game_ready), 32'd1);
    game_drive(x, y, we, wd);
    tick();
    game_req = 1'b0;
    game_we = 1'b0;
    tick();
  endtask

  task automatic vga_drive(input int px, input int py, input logic [5:0] ev);
    vga_read = 1'b1;
    vga_x = 10'(px);
    vga_y = 10'(py);
    vga_q.push_back(ev);
  endtask

  function automatic logic [5:0] pixel_rgb(input int px, input int py);
    int cx, cy;
    cx = px >> 4;
    cy = py >> 4;
    if (cx < W && cy < H) return rgb_of(model[cy][cx]);
    return 6'b0;
  endfunction

  task automatic vga_pixel(input int px, input int py);
    vga_drive(px, py, pixel_rgb(px, py));
    tick();
    vga_read = 1'b0;
  endtask

  task automatic measure_sweep(input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check(tag, 32'(n), 32'd1200);
    check({tag, "_ready"}, 32'(game_ready), 32'd1);
  endtask

  initial begin
    logic [5:0] old_rgb;
    clear_model();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(game_ready), 32'd0);
    check("rst_ack", 32'(game_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(mapa_valid), 32'd0);
    check("rst_rgb", 32'({mapa_R, mapa_G, mapa_B}), 32'd0);
    check("rst_rdata_err", 32'({game_rdata, game_err}), 32'd0);
    tick();
    rst_n = 1'b1;
    measure_sweep("sweep_after_reset");
    tick();

    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        game_access(x, y, 1'b0, 4'h0);

    game_access(5, 7, 1'b1, 4'b0010);
    game_access(5, 7, 1'b0, 4'h0);
    vga_pixel(80, 112);
    vga_pixel(95, 127);
    vga_pixel(96, 112);

    game_access(3, 3, 1'b1, 4'b1100);
    vga_pixel(48, 48);
    game_access(3, 3, 1'b1, 4'b1000);
    vga_pixel(48, 48);
    game_access(4, 3, 1'b1, 4'b1111);
    vga_pixel(64, 63);
    game_access(10, 10, 1'b1, 4'b0001);
    vga_pixel(170, 175);

    game_access(40, 0, 1'b0, 4'h0);
    game_access(0, 30, 1'b0, 4'h0);
    game_access(40, 0, 1'b1, 4'b0010);
    game_access(63, 31, 1'b1, 4'b0010);
    game_access(0, 1, 1'b0, 4'h0);
    game_access(39, 29, 1'b1, 4'b1010);
    game_access(39, 29, 1'b0, 4'h0);

    game_access(0, 0, 1'b1, 4'b0010);
    vga_pixel(640, 0);
    vga_pixel(0, 480);
    vga_pixel(0, 0);
    vga_pixel(639, 479);

    old_rgb = rgb_of(model[6][6]);
    check("game_ready_rbw", 32'(game_ready), 32'd1);
    game_drive(6, 6, 1'b1, 4'b0010);
    tick();
    game_req = 1'b0;
    game_we = 1'b0;
    vga_drive(96, 96, old_rgb);
    tick();
    vga_read = 1'b0;
    vga_pixel(96, 96);

    for (int i = 0; i < 4; i++) begin
      vga_drive(16 * i, 48 + i, pixel_rgb(16 * i, 48 + i));
      tick();
    end
    vga_read = 1'b0;
    repeat (4) tick();
    check("vga_valid_idle", 32'(mapa_valid), 32'd0);
    check("rgb_hold", 32'({mapa_R, mapa_G, mapa_B}), 32'(last_rgb));

    clear_start = 1'b1;
    game_req = 1'b1;
    game_we = 1'b1;
    game_x = 6'd2;
    game_y = 5'd2;
    game_wdata = 4'b0010;
    tick();
    clear_start = 1'b0;
    game_req = 1'b0;
    game_we = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    clear_model();
    vga_drive(80, 112, 6'b0);
    fork
      measure_sweep("sweep_after_clear");
      begin
        tick();
        vga_read = 1'b0;
      end
    join
    tick();
    game_access(5, 7, 1'b0, 4'h0);
    game_access(3, 3, 1'b0, 4'h0);
    game_access(0, 0, 1'b0, 4'h0);
    game_access(2, 2, 1'b0, 4'h0);

    check("game_ready_abort", 32'(game_ready), 32'd1);
    game_req = 1'b1;
    game_we = 1'b1;
    game_x = 6'd2;
    game_y = 5'd2;
    game_wdata = 4'b0010;
    tick();
    game_req = 1'b0;
    game_we = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ack", 32'(game_ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    measure_sweep("sweep_after_abort");
    tick();
    game_access(2, 2, 1'b0, 4'h0);
    vga_pixel(32, 32);

    for (int i = 0; i < 20; i++) begin
      if (game_q.size() == 0 && vga_q.size() == 0) break;
      tick();
    end
    check("game_q_drained", 32'(game_q.size()), 32'd0);
    check("vga_q_drained", 32'(vga_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
